// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall encodings, arbiter states and enable levels for pipe_ctrl
package pipe_ctrl_pkg;

   localparam int STALL_W     = 6;
   localparam int STALL_PC    = 0;
   localparam int STALL_IFID  = 1;
   localparam int STALL_IDEX  = 2;
   localparam int STALL_EXMEM = 3;
   localparam int STALL_MEMWB = 4;

   localparam logic [STALL_W-1:0] STALL_NONE     = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_MEM_PEND = 6'b011111;
   localparam logic [STALL_W-1:0] STALL_IF_PEND  = 6'b000011;
   localparam logic [STALL_W-1:0] STALL_LOAD_USE = 6'b000111;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SERVE_IF  = 2'd1,
      ST_SERVE_MEM = 2'd2
   } arb_state_t;

endpackage

// File: rtl/pipe_ctrl_mem_arbiter.sv
// rtl/pipe_ctrl_mem_arbiter.sv - shared memory port FSM: grant, latch request, pulse done
module mem_arbiter
   import pipe_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic              ram_done_i,
   input  logic              drop_i,
   output logic              ram_req_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              if_done_o,
   output logic              mem_done_o,
   output arb_state_t        state_o
);

   arb_state_t state_q;

   assign state_o = state_q;

   // MEM wins in IDLE; a granted transaction always runs to its ram_done_i.
   always_ff @(posedge clk) begin
      if (rst == ENABLE) begin
         state_q    <= ST_IDLE;
         ram_req_o  <= DISABLE;
         ram_we_o   <= DISABLE;
         ram_addr_o <= '0;
         if_done_o  <= DISABLE;
         mem_done_o <= DISABLE;
      end else begin
         if_done_o  <= DISABLE;
         mem_done_o <= DISABLE;
         case (state_q)
            ST_IDLE: begin
               if (mem_req_i) begin
                  state_q    <= ST_SERVE_MEM;
                  ram_req_o  <= ENABLE;
                  ram_we_o   <= mem_we_i;
                  ram_addr_o <= mem_addr_i;
               end else if (if_req_i) begin
                  state_q    <= ST_SERVE_IF;
                  ram_req_o  <= ENABLE;
                  ram_we_o   <= DISABLE;
                  ram_addr_o <= if_addr_i;
               end
            end
            ST_SERVE_IF: begin
               if (ram_done_i) begin
                  state_q   <= ST_IDLE;
                  ram_req_o <= DISABLE;
                  if_done_o <= ~drop_i;
               end
            end
            ST_SERVE_MEM: begin
               if (ram_done_i) begin
                  state_q    <= ST_IDLE;
                  ram_req_o  <= DISABLE;
                  mem_done_o <= ENABLE;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               ram_req_o <= DISABLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline controller: memory port arbitration, stall vector, branch flush, stall counter
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req_i,
   input  logic [ADDR_W-1:0]  if_addr_i,
   input  logic               mem_req_i,
   input  logic               mem_we_i,
   input  logic [ADDR_W-1:0]  mem_addr_i,
   input  logic               load_use_i,
   input  logic               branch_flag_i,
   input  logic               ram_done_i,
   output logic               ram_req_o,
   output logic               ram_we_o,
   output logic [ADDR_W-1:0]  ram_addr_o,
   output logic               if_done_o,
   output logic               mem_done_o,
   output logic [STALL_W-1:0] stall_o,
   output logic               flush_o,
   output logic [CNT_W-1:0]   stall_cnt_o
);

   arb_state_t         arb_state;
   logic [STALL_W-1:0] stall;
   logic               flush;
   logic               serving_if;
   logic               drop_q, drop_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   assign serving_if = (arb_state == ST_SERVE_IF);

   // A flush landing on the same cycle as the fetch's ram_done_i must also kill that fetch.
   mem_arbiter #(
      .ADDR_W (ADDR_W)
   ) u_mem_arbiter (
      .clk        (clk),
      .rst        (rst),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .mem_req_i  (mem_req_i),
      .mem_we_i   (mem_we_i),
      .mem_addr_i (mem_addr_i),
      .ram_done_i (ram_done_i),
      .drop_i     (drop_q | (flush & serving_if)),
      .ram_req_o  (ram_req_o),
      .ram_we_o   (ram_we_o),
      .ram_addr_o (ram_addr_o),
      .if_done_o  (if_done_o),
      .mem_done_o (mem_done_o),
      .state_o    (arb_state)
   );

   always_comb begin
      stall = STALL_NONE;
      flush = DISABLE;
      if (rst != ENABLE) begin
         if (mem_req_i && !mem_done_o) begin
            stall = stall | STALL_MEM_PEND;
         end
         if ((if_req_i && !if_done_o) || (if_req_i && arb_state == ST_SERVE_MEM)) begin
            stall = stall | STALL_IF_PEND;
         end
         flush = branch_flag_i & ~stall[STALL_EXMEM];
         // The PC must take the branch target, so the front stalls yield to the flush.
         if (flush) begin
            stall[STALL_IDEX:STALL_PC] = '0;
         end else if (load_use_i) begin
            stall = stall | STALL_LOAD_USE;
         end
      end
   end

   always_comb begin
      drop_d = drop_q;
      if (serving_if && ram_done_i) begin
         drop_d = DISABLE;
      end else if (serving_if && flush) begin
         drop_d = ENABLE;
      end
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, |stall};
   end

   always_ff @(posedge clk) begin
      if (rst == ENABLE) begin
         drop_q      <= DISABLE;
         stall_cnt_q <= '0;
      end else begin
         drop_q      <= drop_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_o     = stall;
   assign flush_o     = flush;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized self-checking bench for pipe_ctrl against a cycle-level reference model
module tb_pipe_ctrl;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 8;
   localparam int N_CYC  = 4000;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              mem_req_i;
   logic              mem_we_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic              load_use_i;
   logic              branch_flag_i;
   logic              ram_done_i;
   logic              ram_req_o;
   logic              ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic              if_done_o;
   logic              mem_done_o;
   logic [5:0]        stall_o;
   logic              flush_o;
   logic [CNT_W-1:0]  stall_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   pipe_ctrl #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .if_req_i      (if_req_i),
      .if_addr_i     (if_addr_i),
      .mem_req_i     (mem_req_i),
      .mem_we_i      (mem_we_i),
      .mem_addr_i    (mem_addr_i),
      .load_use_i    (load_use_i),
      .branch_flag_i (branch_flag_i),
      .ram_done_i    (ram_done_i),
      .ram_req_o     (ram_req_o),
      .ram_we_o      (ram_we_o),
      .ram_addr_o    (ram_addr_o),
      .if_done_o     (if_done_o),
      .mem_done_o    (mem_done_o),
      .stall_o       (stall_o),
      .flush_o       (flush_o),
      .stall_cnt_o   (stall_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: who owns the port (0 none, 1 fetch, 2 mem) and what the pipeline sees.
   int          owner;
   logic [31:0] m_addr;
   logic        m_we, m_idone, m_mdone, m_drop, m_fresh;
   int          m_cnt;

   initial begin
      bit          mem_pend, if_pend, e_flush;
      logic [5:0]  e_stall;

      rst = 1'b1; if_req_i = 0; if_addr_i = '0; mem_req_i = 0; mem_we_i = 0;
      mem_addr_i = '0; load_use_i = 0; branch_flag_i = 0; ram_done_i = 0;
      owner = 0; m_addr = '0; m_we = 0; m_idone = 0; m_mdone = 0; m_drop = 0;
      m_fresh = 1; m_cnt = 0;

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc >= 2) begin
            rst           = ($urandom_range(0, 99) < 2);
            if_req_i      = ($urandom_range(0, 99) < 65);
            if_addr_i     = $urandom & 32'hFFFC;
            mem_req_i     = ($urandom_range(0, 99) < 25);
            mem_we_i      = $urandom_range(0, 1);
            mem_addr_i    = $urandom;
            load_use_i    = ($urandom_range(0, 99) < 15);
            branch_flag_i = ($urandom_range(0, 99) < 15);
            ram_done_i    = ($urandom_range(0, 99) < 35);
         end
         @(negedge clk);

         mem_pend = mem_req_i && !m_mdone;
         if_pend  = if_req_i && (!m_idone || owner == 2);
         e_flush  = !rst && branch_flag_i && !mem_pend;
         if (rst || e_flush) e_stall = 6'd0;
         else e_stall = (mem_pend ? 6'h1F : 6'h00) | (if_pend ? 6'h03 : 6'h00) |
                        (load_use_i ? 6'h07 : 6'h00);

         chk("ram_req", ram_req_o, owner != 0);
         chk("if_done", if_done_o, m_idone);
         chk("mem_done", mem_done_o, m_mdone);
         chk("stall", stall_o, e_stall);
         chk("flush", flush_o, e_flush);
         chk("stall_cnt", stall_cnt_o, m_cnt);
         if (owner != 0 || m_fresh) begin
            chk("ram_addr", ram_addr_o, m_addr);
            chk("ram_we", ram_we_o, m_we);
         end

         if (rst) begin
            owner = 0; m_addr = '0; m_we = 0; m_idone = 0; m_mdone = 0;
            m_drop = 0; m_cnt = 0; m_fresh = 1;
         end else begin
            if (e_stall != 0) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            m_idone = 0;
            m_mdone = 0;
            if (owner == 0) begin
               if (mem_req_i) begin
                  owner = 2; m_addr = mem_addr_i; m_we = mem_we_i; m_fresh = 0;
               end else if (if_req_i) begin
                  owner = 1; m_addr = if_addr_i; m_we = 0; m_fresh = 0;
               end
            end else if (owner == 1) begin
               if (ram_done_i) begin
                  m_idone = !(m_drop || e_flush);
                  m_drop  = 0;
                  owner   = 0;
               end else if (e_flush) begin
                  m_drop = 1;
               end
            end else if (ram_done_i) begin
               m_mdone = 1;
               owner   = 0;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core. Owns the single shared memory port, arbitrates it between instruction fetch (IF) and the MEM stage, and sequences multi-cycle accesses with a small FSM.
- Generates the per-stage stall vector and the branch flush that the inter-stage registers (if_id, id_ex, ex_mem, mem_wb) consume.
- Discards a fetch that is in flight when a branch is taken, and counts stall cycles for performance debug.

Parameters:
- ADDR_W, 32, memory address width
- CNT_W, 32, stall-cycle counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset (`Enable = 1)
- if_req_i  in  1  IF requests an instruction fetch
- if_addr_i  in  ADDR_W  fetch address (PC)
- mem_req_i  in  1  MEM stage requests a load/store
- mem_we_i  in  1  MEM access is a store
- mem_addr_i  in  ADDR_W  MEM access address
- load_use_i  in  1  ID detected a load-use hazard
- branch_flag_i  in  1  EX resolved a taken branch/jump this cycle
- ram_done_i  in  1  memory completes the current transaction (1-cycle pulse)
- ram_req_o  out  1  memory transaction active
- ram_we_o  out  1  write enable for the current transaction
- ram_addr_o  out  ADDR_W  address of the current transaction
- if_done_o  out  1  fetch data valid this cycle (1-cycle pulse)
- mem_done_o  out  1  MEM data valid/store complete (1-cycle pulse)
- stall_o  out  6  [0] pc, [1] if/id, [2] id/ex, [3] ex/mem, [4] mem/wb, [5] reserved (always 0)
- flush_o  out  1  branch flush to if_id and id_ex
- stall_cnt_o  out  CNT_W  cycles with any stall_o bit set

Behaviour:
- FSM states: IDLE, SERVE_IF, SERVE_MEM. ram_req_o=1 exactly in SERVE_IF/SERVE_MEM. ram_addr_o/ram_we_o are latched on entry and held stable until done.
- Arbitration (IDLE): mem_req_i wins over if_req_i. mem_req_i -> SERVE_MEM (latch mem_addr_i, mem_we_i). Else if_req_i -> SERVE_IF (latch if_addr_i, we=0). Else stay IDLE.
- SERVE_x with ram_done_i=1: pulse the matching done, return to IDLE. Back-to-back requests therefore cost one IDLE cycle each; there is no same-cycle re-grant.
- A mem_req_i arriving during SERVE_IF waits until the fetch completes; transactions are never preempted.
- Stall priority, combinational from state and inputs, highest first:
  - MEM pending (mem_req_i=1 and mem_done_o=0): stall_o=011111.
  - IF pending (if_req_i=1 and if_done_o=0), or port busy for MEM while IF wants it: stall_o=000011.
  - load_use_i: stall_o=000111. Stage ex/mem is not stalled, so id_ex emits a bubble.
  - Otherwise: 000000.
  - Bits are ORed when several conditions hold.
- Flush:
  - flush_o = branch_flag_i and not stall_o[3]. A branch under a MEM stall is held in EX and flushes on the first unstalled cycle.
  - flush_o overrides load_use_i: stall_o[2:0] forced to 0 that cycle.
- Fetch drop: a taken flush while in SERVE_IF sets drop_q. The eventual ram_done_i completes the transaction but if_done_o is suppressed; drop_q clears on that done. PC refetch is issued afterwards.
- stall_cnt_o increments (wraps at 2^CNT_W) each cycle any stall_o bit is 1.
- Reset, including mid-transaction, takes effect the next edge:
  - state=IDLE, ram_req_o=0, ram_we_o=0, ram_addr_o=0, if_done_o=0, mem_done_o=0, drop_q=0, stall_cnt_o=0.
  - During rst=1, stall_o=000000 and flush_o=0.
  - The memory side must tolerate an abandoned transaction; a ram_done_i arriving in IDLE is ignored.
- Done outputs are registered: they are high the cycle after ram_done_i, and stalls release that cycle.

Decomposition:
- defines.v gets: `StallBus 5:0, stall bit indices (`StallPC … `StallMEMWB), FSM state encodings (2 bits), `Enable/`Disable, `ZeroWord.
- Sub-module mem_arbiter holds the FSM, latch registers and done pulses. pipe_ctrl keeps the stall/flush logic, drop_q and the counter.

Test Plan:
- if_req_i=1, addr=0x100, ram_done_i 3 cycles after grant -> ram_addr_o=0x100, stall_o=000011 for 4 cycles, if_done_o pulses once, stall_cnt_o=4.
- if_req_i and mem_req_i (addr 0x2000, we=1) asserted the same cycle -> SERVE_MEM first with ram_we_o=1 and stall_o=011111. After mem_done_o, one IDLE cycle, then SERVE_IF.
- load_use_i=1 for 1 cycle, no memory activity -> stall_o=000111 for that cycle, flush_o=0.
- branch_flag_i=1 during SERVE_IF -> flush_o=1. The following ram_done_i produces no if_done_o, and the next fetch is granted after IDLE.
- branch_flag_i=1 while MEM pending -> flush_o=0 until mem_done_o, then flush_o=1 for one cycle.
- rst=1 in SERVE_MEM -> next cycle ram_req_o=0, state IDLE, stall_cnt_o=0. A stray ram_done_i yields no done pulse.
